// File: rtl/axi4_mem_slave.sv
// AXI4 memory responder: serialised single-transaction burst reads/writes against
// an on-chip 64-bit word array, with DECERR for addresses outside the decoded window.
module axi4_mem_slave #(
  parameter logic [31:0] MEM_BASE   = 32'h0010_0000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        resetn,
  // AW channel
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // W channel
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  // B channel
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  // AR channel
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // R channel
  output logic        rvalid,
  input  logic        rready,
  output logic [3:0]  rid,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [32:0] WINDOW = 33'(DEPTH) << 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {RST, IDLE, WDATA, WRESP, RDATA} state_t;

  state_t state, state_next;

  logic [3:0]  txn_id;
  logic [31:0] txn_addr;
  logic [7:0]  txn_len;
  logic [2:0]  txn_size;
  logic [1:0]  txn_burst;
  logic [7:0]  beat;
  logic        dec_err, slv_err;
  logic        prio_w;

  logic [1:0]  bresp_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic [63:0] mem [DEPTH];

  // The in-range test uses the full 32-bit address; the word index is truncated.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a - MEM_BASE} < WINDOW);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - MEM_BASE) >> 3);
  endfunction

  logic        aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic [31:0] step, addr_next, rd_addr;
  logic        last_beat, rd_hit, wr_hit, beat_dec, beat_slv;
  logic [63:0] rd_word;
  logic [DEPTH_LOG2-1:0] wr_idx;

  assign awready = (state == IDLE) & awvalid & (~arvalid | prio_w);
  assign arready = (state == IDLE) & arvalid & (~awvalid | ~prio_w);
  assign wready  = (state == WDATA);
  assign bvalid  = (state == WRESP);
  assign rvalid  = (state == RDATA);

  assign bid   = txn_id;
  assign bresp = bresp_q;
  assign rid   = txn_id;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rlast = rlast_q;

  assign aw_hs = awvalid & awready;
  assign ar_hs = arvalid & arready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  // WRAP and reserved burst types advance like INCR.
  assign step      = (txn_burst == BURST_FIXED) ? 32'd0 : (32'd1 << txn_size);
  assign addr_next = txn_addr + step;
  assign last_beat = (beat == txn_len);

  // Read port looks at the incoming address in IDLE and the following beat in RDATA.
  assign rd_addr = (state == IDLE) ? araddr : addr_next;
  assign rd_hit  = in_range(rd_addr);
  assign rd_word = mem[word_idx(rd_addr)];

  assign wr_hit   = in_range(txn_addr);
  assign wr_idx   = word_idx(txn_addr);
  assign beat_dec = ~wr_hit;
  assign beat_slv = (wlast != last_beat);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      RST:   state_next = IDLE;
      IDLE: begin
        if (aw_hs)      state_next = WDATA;
        else if (ar_hs) state_next = RDATA;
      end
      WDATA: if (w_hs && last_beat) state_next = WRESP;
      WRESP: if (b_hs)              state_next = IDLE;
      RDATA: if (r_hs && rlast_q)   state_next = IDLE;
      default: state_next = RST;
    endcase
  end

  // NOTE: registers are updated with <= so every process sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RST;
      txn_id    <= '0;
      txn_addr  <= '0;
      txn_len   <= '0;
      txn_size  <= '0;
      txn_burst <= '0;
      beat      <= '0;
      dec_err   <= 1'b0;
      slv_err   <= 1'b0;
      prio_w    <= 1'b1;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      state <= state_next;

      if (aw_hs || ar_hs) begin
        prio_w    <= ~prio_w;
        beat      <= '0;
        dec_err   <= 1'b0;
        slv_err   <= 1'b0;
        txn_id    <= aw_hs ? awid    : arid;
        txn_addr  <= aw_hs ? awaddr  : araddr;
        txn_len   <= aw_hs ? awlen   : arlen;
        txn_size  <= aw_hs ? awsize  : arsize;
        txn_burst <= aw_hs ? awburst : arburst;
      end

      // Beat 0 is fetched on the AR handshake so rvalid can rise the next cycle.
      if (ar_hs) begin
        rdata_q <= rd_hit ? rd_word : 64'd0;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_DECERR;
        rlast_q <= (arlen == 8'd0);
      end

      if (r_hs && !rlast_q) begin
        beat     <= beat + 8'd1;
        txn_addr <= addr_next;
        rdata_q  <= rd_hit ? rd_word : 64'd0;
        rresp_q  <= rd_hit ? RESP_OKAY : RESP_DECERR;
        rlast_q  <= ((beat + 8'd1) == txn_len);
      end

      if (w_hs) begin
        beat     <= beat + 8'd1;
        txn_addr <= addr_next;
        if (beat_dec) dec_err <= 1'b1;
        if (beat_slv) slv_err <= 1'b1;
        if (last_beat) begin
          if (dec_err || beat_dec)      bresp_q <= RESP_DECERR;
          else if (slv_err || beat_slv) bresp_q <= RESP_SLVERR;
          else                          bresp_q <= RESP_OKAY;
        end
      end
    end
  end

  // NOTE: the array has no reset so contents survive a reset and it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_hs && wr_hit) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Self-checking bench for axi4_mem_slave: directed scenarios plus random bursts
// compared against a word-array reference model driven by the AXI burst rules.
module tb_axi4_mem_slave;

  localparam logic [31:0] MEM_BASE = 32'h0010_0000;
  localparam int          DEPTH    = 4096;

  logic        clk = 1'b0;
  logic        resetn;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  always #5 clk = ~clk;

  axi4_mem_slave #(.MEM_BASE(MEM_BASE), .DEPTH_LOG2(12)) dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] model_mem [DEPTH];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x >= 64'(MEM_BASE)) && (x < 64'(MEM_BASE) + 64'(8 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - MEM_BASE;
    return int'(d / 32'd8) % DEPTH;
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] size,
                                      input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  function automatic logic [81:0] all_outputs();
    return {awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata};
  endfunction

  // Write burst from wbuf/sbuf; early_last >= 0 puts wlast on that beat instead of the last.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int early_last, input bit bp);
    logic [31:0] a;
    bit          dec;
    bit          slv;
    logic [1:0]  exp_resp;
    int          n;
    int          stall;
    dec = 0;
    slv = 0;
    @(negedge clk);
    awvalid = 1; awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
    n = 0;
    #1;
    while (!awready && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check("aw_grant", awready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 0;
    a = addr;
    for (int k = 0; k <= len; k++) begin
      wvalid = 1; wdata = wbuf[k]; wstrb = sbuf[k];
      wlast  = (early_last >= 0) ? (k == early_last) : (k == len);
      if (wlast != (k == len)) slv = 1;
      #1 check("wready", wready, 1'b1);
      if (in_win(a)) begin
        for (int b = 0; b < 8; b++)
          if (sbuf[k][b]) model_mem[widx(a)][8*b +: 8] = wbuf[k][8*b +: 8];
      end else begin
        dec = 1;
      end
      a = nxt(a, size, burst);
      @(posedge clk);
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    stall = bp ? $urandom_range(1, 3) : 0;
    for (int i = 0; i <= stall; i++) begin
      #1;
      check("bvalid", bvalid, 1'b1);
      check("bresp", bresp, exp_resp);
      check("bid", bid, id);
      if (i == stall) bready = 1;
      else @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    #1 check("b_done", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input bit bp);
    logic [31:0] a;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    int          n;
    int          stall;
    @(negedge clk);
    arvalid = 1; arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
    n = 0;
    #1;
    while (!arready && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check("ar_grant", arready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    a = addr;
    for (int k = 0; k <= len; k++) begin
      exp_d = in_win(a) ? model_mem[widx(a)] : 64'd0;
      exp_r = in_win(a) ? 2'b00 : 2'b11;
      stall = bp ? $urandom_range(0, 2) : 0;
      for (int i = 0; i <= stall; i++) begin
        rready = (i == stall);
        #1;
        check("rvalid", rvalid, 1'b1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        check("rlast", rlast, (k == len));
        check("rid", rid, id);
        @(posedge clk);
        @(negedge clk);
      end
      a = nxt(a, size, burst);
    end
    rready = 0;
    #1 check("r_done", rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [31:0] addr;
    int          len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          early;

    resetn = 0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", all_outputs(), 82'd0);

    // Simultaneous AW/AR right after reset: no grant in RST, then write first, read next.
    d = 64'hA5A5_0000_DEAD_BEEF;
    @(negedge clk);
    resetn = 1;
    awvalid = 1; awid = 4'd1; awaddr = MEM_BASE; awlen = 0; awsize = 3; awburst = 2'b01;
    arvalid = 1; arid = 4'd2; araddr = MEM_BASE; arlen = 0; arsize = 3; arburst = 2'b01;
    #1 check("rst_no_grant", {awready, arready}, 2'b00);
    @(posedge clk); @(negedge clk);
    #1 check("arb_write_first", {awready, arready}, 2'b10);
    @(posedge clk); @(negedge clk);
    awvalid = 0;
    wvalid = 1; wdata = d; wstrb = 8'hFF; wlast = 1;
    #1 check("arb_read_blocked", {wready, arready}, 2'b10);
    @(posedge clk); @(negedge clk);
    wvalid = 0; wlast = 0; bready = 1;
    #1 check("arb_bresp", {bvalid, bresp, bid}, {1'b1, 2'b00, 4'd1});
    @(posedge clk); @(negedge clk);
    bready = 0; awvalid = 1;
    #1 check("arb_read_next", {awready, arready}, 2'b01);
    @(posedge clk); @(negedge clk);
    awvalid = 0; arvalid = 0; rready = 1;
    #1 check("arb_rdata", {rvalid, rlast, rresp, rid, rdata}, {1'b1, 1'b1, 2'b00, 4'd2, d});
    @(posedge clk); @(negedge clk);
    rready = 0;
    model_mem[0] = d;

    // Fill the whole array so every later read has a known value.
    for (int blk = 0; blk < 16; blk++) begin
      for (int k = 0; k < 256; k++) begin
        wbuf[k] = {$urandom(), $urandom()};
        sbuf[k] = 8'hFF;
      end
      axi_write(4'(blk), MEM_BASE + 32'(blk * 2048), 255, 3'd3, 2'b01, -1, 0);
    end

    // Single write then read.
    wbuf[0] = 64'h1122_3344_5566_7788; sbuf[0] = 8'hFF;
    axi_write(4'd5, MEM_BASE, 0, 3'd3, 2'b01, -1, 0);
    axi_read(4'd9, MEM_BASE, 0, 3'd3, 2'b01, 0);

    // INCR burst of four beats, read back with rready held.
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = 64'(k + 1); sbuf[k] = 8'hFF;
    end
    axi_write(4'd6, MEM_BASE + 32'h40, 3, 3'd3, 2'b01, -1, 0);
    axi_read(4'd7, MEM_BASE + 32'h40, 3, 3'd3, 2'b01, 0);

    // Partial strobes over a zeroed word.
    wbuf[0] = 64'd0; sbuf[0] = 8'hFF;
    axi_write(4'd3, MEM_BASE + 32'h100, 0, 3'd3, 2'b01, -1, 0);
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'h0F;
    axi_write(4'd3, MEM_BASE + 32'h100, 0, 3'd3, 2'b01, -1, 0);
    axi_read(4'd3, MEM_BASE + 32'h100, 0, 3'd3, 2'b01, 0);

    // FIXED burst: both beats land on one word, the second wins.
    wbuf[0] = 64'h0BAD_F00D_0000_0001; wbuf[1] = 64'h600D_CAFE_0000_0002;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(4'd8, MEM_BASE + 32'h200, 1, 3'd3, 2'b00, -1, 0);
    axi_read(4'd8, MEM_BASE + 32'h200, 0, 3'd3, 2'b01, 0);

    // Out of range write aliases word 0 after truncation; memory must not change.
    wbuf[0] = 64'h5555_AAAA_5555_AAAA; sbuf[0] = 8'hFF;
    axi_write(4'd1, 32'h8000_0000, 0, 3'd3, 2'b01, -1, 0);
    axi_read(4'd1, MEM_BASE, 0, 3'd3, 2'b01, 0);
    axi_read(4'd2, 32'h0010_7FF8, 1, 3'd3, 2'b01, 0);

    // Backpressure on R and B, and an early wlast.
    axi_read(4'd4, MEM_BASE + 32'h40, 3, 3'd3, 2'b01, 1);
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = {$urandom(), $urandom()}; sbuf[k] = 8'hFF;
    end
    axi_write(4'd4, MEM_BASE + 32'h300, 3, 3'd3, 2'b01, 1, 1);
    axi_read(4'd4, MEM_BASE + 32'h300, 3, 3'd3, 2'b01, 1);

    // Reset asserted while beat 2 of a len-7 read is on the bus.
    @(negedge clk);
    arvalid = 1; arid = 4'd3; araddr = MEM_BASE + 32'd800; arlen = 8'd7;
    arsize = 3'd3; arburst = 2'b01;
    #1 check("mid_ar_grant", arready, 1'b1);
    @(posedge clk); @(negedge clk);
    arvalid = 0; rready = 1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    #1 check("mid_beat2", {rvalid, rdata}, {1'b1, model_mem[102]});
    resetn = 0;
    #1 check("mid_reset_outputs", all_outputs(), 82'd0);
    rready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    axi_read(4'd5, MEM_BASE + 32'd800, 7, 3'd3, 2'b01, 0);
    axi_read(4'd5, MEM_BASE + 32'h40, 3, 3'd3, 2'b01, 0);

    // Random traffic against the model.
    for (int t = 0; t < 60; t++) begin
      len   = $urandom_range(0, 15);
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       addr = $urandom() & 32'hFFFF_FFF8;
        1:       addr = MEM_BASE + 32'h8000 - 32'(8 * $urandom_range(1, 4));
        default: addr = MEM_BASE + 32'(8 * $urandom_range(0, DEPTH - 1));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k <= len; k++) begin
          wbuf[k] = {$urandom(), $urandom()};
          sbuf[k] = 8'($urandom());
        end
        early = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        axi_write(4'($urandom()), addr, len, size, burst, early, 1'($urandom()));
      end else begin
        axi_read(4'($urandom()), addr, len, size, burst, 1'($urandom()));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
